// File: rtl/vector_pkg.sv
// Shared types and default sizing for the vector lane serializer.
// Lane 0 of a packed vector occupies the least significant bits.
package vector_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_LANES      = 6;
  localparam int DEFAULT_ADDR_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } ser_state_t;

  typedef logic [DEFAULT_LANES-1:0][DEFAULT_DATA_WIDTH-1:0] lane_vec_t;

endpackage

// File: rtl/vector_lane_serializer.sv
// Store path from the vector execute stage: takes one packed vector and
// writes its enabled lanes one per cycle to a DATA_WIDTH-wide memory port.
module vector_lane_serializer
  import vector_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int LANES      = DEFAULT_LANES,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_WIDTH*LANES-1:0] in_data,
  input  logic [ADDR_WIDTH-1:0]       in_base_addr,
  input  logic [LANES-1:0]            in_lane_mask,
  output logic                        mem_we,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic [DATA_WIDTH-1:0]       mem_wdata,
  input  logic                        mem_ready,
  output logic                        busy,
  output logic                        done
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int VEC_W = DATA_WIDTH * LANES;

  ser_state_t             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [VEC_W-1:0]       data_q, data_d;
  logic [ADDR_WIDTH-1:0]  base_q, base_d;
  logic [LANES-1:0]       mask_q, mask_d;

  logic                   lane_en;
  logic                   advance;
  logic [VEC_W-1:0]       lane_shift;

  assign lane_en    = mask_q[idx_q];
  assign lane_shift = data_q >> (int'(idx_q) * DATA_WIDTH);
  // Masked-off lanes never wait on memory; enabled lanes wait for mem_ready.
  assign advance    = !lane_en || mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      base_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      base_q  <= base_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    base_d  = base_q;
    mask_d  = mask_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          base_d  = in_base_addr;
          mask_d  = in_lane_mask;
          idx_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (advance) begin
          if (idx_q == IDX_W'(LANES - 1)) begin
            idx_d   = '0;
            state_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend only on flops, so in_* never reaches mem_* combinationally.
  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == BUSY && lane_en) begin
      mem_we    = 1'b1;
      mem_addr  = base_q + ADDR_WIDTH'(idx_q);
      mem_wdata = lane_shift[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_vector_lane_serializer.sv
// Directed scoreboard bench for vector_lane_serializer: expected writes are
// queued when a vector is driven and popped as the memory port accepts them.
module tb_vector_lane_serializer;

   localparam int DW = 8;
   localparam int NL = 6;
   localparam int AW = 16;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [DW*NL-1:0]  in_data;
   logic [AW-1:0]     in_base_addr;
   logic [NL-1:0]     in_lane_mask;
   logic              mem_we;
   logic [AW-1:0]     mem_addr;
   logic [DW-1:0]     mem_wdata;
   logic              mem_ready;
   logic              busy;
   logic              done;

   wr_t expQ[$];
   int  nCompared = 0;
   int  nMismatched = 0;
   int  writeCount;
   int  busyCycles;

   vector_lane_serializer #(
      .DATA_WIDTH(DW),
      .LANES(NL),
      .ADDR_WIDTH(AW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .in_base_addr(in_base_addr),
      .in_lane_mask(in_lane_mask),
      .mem_we(mem_we),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_ready(mem_ready),
      .busy(busy),
      .done(done)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      nCompared++;
      assert (observed === expected) else begin
         nMismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Offer a vector, queue its expected writes, and return in cycle 1 after acceptance.
   task automatic applyStimulus(input logic [DW*NL-1:0] data, input logic [AW-1:0] base,
                                input logic [NL-1:0] mask);
      int waited;
      wr_t w;
      waited = 0;
      while (!in_ready && waited < 50) begin
         stepCycle();
         waited++;
      end
      checkOutput("accept_wait_ready", {31'd0, in_ready}, 32'd1);
      in_valid     = 1'b1;
      in_data      = data;
      in_base_addr = base;
      in_lane_mask = mask;
      for (int i = 0; i < NL; i++) begin
         if (mask[i]) begin
            w.addr = base + AW'(i);
            w.data = data[i*DW +: DW];
            expQ.push_back(w);
         end
      end
      stepCycle();
      in_valid = 1'b0;
   endtask

   // Walk one vector from cycle 1, stalling mem_ready for stallLen cycles from stallFrom.
   task automatic runVector(input string tag, input int stallFrom, input int stallLen,
                            input int expDone, input int expWrites, input int expBusy);
      bit seenDone;
      seenDone   = 0;
      writeCount = 0;
      busyCycles = 0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         mem_ready = !(cyc >= stallFrom && cyc < stallFrom + stallLen);
         if (done) begin
            checkOutput({tag, "_done_cycle"}, 32'(cyc), 32'(expDone));
            checkOutput({tag, "_done_we"}, {31'd0, mem_we}, 32'd0);
            checkOutput({tag, "_done_in_ready"}, {31'd0, in_ready}, 32'd0);
            seenDone = 1;
            stepCycle();
            checkOutput({tag, "_done_width"}, {31'd0, done}, 32'd0);
            checkOutput({tag, "_ready_after"}, {31'd0, in_ready}, 32'd1);
            checkOutput({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
            break;
         end
         if (busy) busyCycles++;
         if (mem_we) begin
            if (expQ.size() == 0) begin
               checkOutput({tag, "_extra_write"}, 32'(expQ.size()), 32'd1);
            end else begin
               checkOutput({tag, "_addr"}, 32'(mem_addr), 32'(expQ[0].addr));
               checkOutput({tag, "_data"}, 32'(mem_wdata), 32'(expQ[0].data));
               if (mem_ready) begin
                  void'(expQ.pop_front());
                  writeCount++;
               end
            end
         end else if (busy) begin
            checkOutput({tag, "_idle_addr"}, 32'(mem_addr), 32'd0);
            checkOutput({tag, "_idle_data"}, 32'(mem_wdata), 32'd0);
         end
         stepCycle();
      end
      mem_ready = 1'b1;
      checkOutput({tag, "_done_seen"}, {31'd0, seenDone}, 32'd1);
      checkOutput({tag, "_write_count"}, 32'(writeCount), 32'(expWrites));
      checkOutput({tag, "_busy_cycles"}, 32'(busyCycles), 32'(expBusy));
      checkOutput({tag, "_leftover"}, 32'(expQ.size()), 32'd0);
   endtask

   localparam logic [DW*NL-1:0] VEC_A = 48'h060504030201;
   localparam logic [DW*NL-1:0] VEC_B = 48'hA6A5A4A3A2A1;

   initial begin
      int weSeen;
      int doneSeen;
      rst_n        = 1'b0;
      in_valid     = 1'b0;
      in_data      = '0;
      in_base_addr = '0;
      in_lane_mask = '0;
      mem_ready    = 1'b1;

      #3;
      checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
      checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
      checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
      checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      stepCycle();

      $display("[TB] full mask, no stalls");
      applyStimulus(VEC_A, 16'h0100, 6'b111111);
      runVector("full", 0, 0, 7, 6, 6);

      $display("[TB] sparse mask");
      applyStimulus(VEC_A, 16'h0200, 6'b000101);
      runVector("sparse", 0, 0, 7, 2, 6);

      $display("[TB] memory stall on lane 2");
      applyStimulus(VEC_A, 16'h0100, 6'b111111);
      runVector("stall", 3, 3, 10, 6, 9);

      $display("[TB] address wrap");
      applyStimulus(VEC_A, 16'hFFFE, 6'b111111);
      runVector("wrap", 0, 0, 7, 6, 6);

      $display("[TB] async reset mid-vector");
      applyStimulus(VEC_A, 16'h0400, 6'b111111);
      repeat (3) stepCycle();
      checkOutput("abort_lane3_addr", 32'(mem_addr), 32'h0403);
      checkOutput("abort_lane3_we", {31'd0, mem_we}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("abort_we", {31'd0, mem_we}, 32'd0);
      checkOutput("abort_busy", {31'd0, busy}, 32'd0);
      checkOutput("abort_addr", 32'(mem_addr), 32'd0);
      expQ.delete();
      @(negedge clk);
      rst_n = 1'b1;
      stepCycle();
      checkOutput("abort_in_ready", {31'd0, in_ready}, 32'd1);
      weSeen   = 0;
      doneSeen = 0;
      for (int c = 0; c < 10; c++) begin
         if (mem_we) weSeen++;
         if (done) doneSeen++;
         stepCycle();
      end
      checkOutput("abort_no_writes", 32'(weSeen), 32'd0);
      checkOutput("abort_no_done", 32'(doneSeen), 32'd0);

      $display("[TB] in_valid held through busy");
      applyStimulus(VEC_A, 16'h0500, 6'b111111);
      in_valid     = 1'b1;
      in_data      = VEC_B;
      in_base_addr = 16'h0300;
      in_lane_mask = 6'b111111;
      runVector("hold_first", 0, 0, 7, 6, 6);
      applyStimulus(VEC_B, 16'h0300, 6'b111111);
      runVector("hold_second", 0, 0, 7, 6, 6);

      $display("[TB] zero mask");
      applyStimulus(VEC_B, 16'h0700, 6'b000000);
      runVector("zero_mask", 0, 0, 7, 0, 6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
